// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned FETCH_DEPTH = 2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order instruction buffer of {pc, instr} entries with a single-cycle flush.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic                               push_i,
  input  fetch_entry_t                       push_data_i,
  input  logic                               pop_i,
  output logic                               valid_o,
  output fetch_entry_t                       head_o,
  output logic [$clog2(FETCH_DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CntW = $clog2(FETCH_DEPTH + 1);
  localparam int unsigned PtrW = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;

  fetch_entry_t mem_q [FETCH_DEPTH];
  fetch_entry_t mem_d [FETCH_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    // A full buffer can still take a write when the head leaves in the same cycle.
    do_push  = push_i && ((count_q != CntW'(FETCH_DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc sequencing, credit-based request issue, redirect with
// drop of stale in-flight responses, and a registered buffer toward decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instruction,
  output logic [XLEN-1:0] out_pc
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      inflight_q, inflight_d;
  logic [1:0]      drop_q, drop_d;
  // pcs of outstanding requests, oldest in slot 0
  logic [XLEN-1:0] tag_q [2];
  logic [XLEN-1:0] tag_d [2];

  logic            req_fire, out_fire, resp_keep;
  logic [2:0]      credit_sum;
  logic [1:0]      tag_slot;
  logic [1:0]      fifo_count;
  logic            fifo_valid;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_push_data;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  fetch_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (resp_keep),
    .push_data_i (fifo_push_data),
    .pop_i       (out_fire),
    .valid_o     (fifo_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  always_comb begin
    out_fire   = fifo_valid && out_ready;
    // Outstanding requests plus buffered entries may never exceed the buffer size.
    credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count} - 3'(out_fire);
    imem_req_valid = !rst && !redirect_valid && (credit_sum < 3'(FETCH_DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    resp_keep      = imem_resp_valid && !redirect_valid && (drop_q == 2'd0);
    fifo_push_data = '{pc: tag_q[0], instr: imem_resp_data};

    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end

    inflight_d = inflight_q + 2'(req_fire) - 2'(imem_resp_valid);

    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = inflight_q - 2'(imem_resp_valid);
    end else if (imem_resp_valid && (drop_q != 2'd0)) begin
      drop_d = drop_q - 2'd1;
    end

    tag_d    = tag_q;
    tag_slot = inflight_q - 2'(imem_resp_valid);
    if (imem_resp_valid) begin
      tag_d[0] = tag_q[1];
    end
    if (req_fire) begin
      tag_d[tag_slot[0]] = pc_q;
    end

    out_valid       = fifo_valid;
    out_instruction = fifo_valid ? fifo_head.instr : NOP_INSTR;
    out_pc          = fifo_valid ? fifo_head.pc : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      tag_q      <= tag_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  int n_cmp;
  int n_err;
  int cyc;
  int lat;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pq[$];
  logic [31:0] pc_log[$];
  logic [31:0] ins_log[$];

  fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: instruction word is the bitwise inverse of its address.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = ~pq[0].addr;
      void'(pq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pq.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      pq.push_back('{addr: imem_req_addr, due: cyc + lat});
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pc_log.push_back(out_pc);
      ins_log.push_back(out_instruction);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ends at cycle 0: the first cycle with rst low.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    step(2);
    pc_log.delete();
    ins_log.delete();
    rst = 1'b0;
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] exp_pc);
    check_eq({tag, "_size_ok"}, 32'(pc_log.size() > idx), 32'd1);
    if (pc_log.size() > idx) begin
      check_eq({tag, "_pc"}, pc_log[idx], exp_pc);
      check_eq({tag, "_instr"}, ins_log[idx], ~exp_pc);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    lat   = 1;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;

    // Reset state
    step(2);
    @(negedge clk);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_instr", out_instruction, 32'h0000_0013);
    check_eq("rst_out_pc", out_pc, 32'h0);

    // Reset release, L=1: sequential fetch, first output at cycle 2
    do_reset();
    @(negedge clk);
    check_eq("c0_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("c0_req_addr", imem_req_addr, 32'h0);
    step(1);
    @(negedge clk);
    check_eq("c1_req_addr", imem_req_addr, 32'h4);
    check_eq("c1_out_valid", 32'(out_valid), 32'd0);
    step(1);
    @(negedge clk);
    check_eq("c2_out_valid", 32'(out_valid), 32'd1);
    check_eq("c2_out_pc", out_pc, 32'h0);
    step(1);
    @(negedge clk);
    check_eq("c3_out_pc", out_pc, 32'h4);
    check_eq("c3_inflight", 32'(dut.inflight_q), 32'd1);
    step(4);
    for (int i = 0; i < 5; i++) check_log("seq", i, 32'(i * 4));

    // Decoder stall: buffer fills, requests stop, order preserved on release
    out_ready = 1'b0;
    do_reset();
    step(4);
    @(negedge clk);
    check_eq("stall_count", 32'(dut.u_fifo.count_q), 32'd2);
    check_eq("stall_inflight", 32'(dut.inflight_q), 32'd0);
    check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("stall_out_pc", out_pc, 32'h0);
    step(1);
    out_ready = 1'b1;
    step(8);
    for (int i = 0; i < 4; i++) check_log("stall", i, 32'(i * 4));

    // L=3: two requests in flight, redirect drops both responses
    lat = 3;
    do_reset();
    step(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    check_eq("l3_redir_req_valid", 32'(imem_req_valid), 32'd0);
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("l3_drop_count", 32'(dut.drop_q), 32'd2);
    check_eq("l3_out_valid", 32'(out_valid), 32'd0);
    step(12);
    check_eq("l3_drop_done", 32'(dut.drop_q), 32'd0);
    check_log("l3", 0, 32'h100);
    check_log("l3", 1, 32'h104);

    // Redirect coincident with response and out fire
    lat = 1;
    do_reset();
    step(4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    check_eq("co_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("co_resp_valid", 32'(imem_resp_valid), 32'd1);
    check_eq("co_out_pc", out_pc, 32'h8);
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("co_out_valid", 32'(out_valid), 32'd0);
    check_eq("co_nop", out_instruction, 32'h0000_0013);
    check_eq("co_req_addr", imem_req_addr, 32'h40);
    check_eq("co_req_valid2", 32'(imem_req_valid), 32'd1);
    step(6);
    check_log("co", 2, 32'h8);
    check_log("co", 3, 32'h40);
    check_log("co", 4, 32'h44);

    // Unaligned redirect target and address wrap
    do_reset();
    step(4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("align_addr", imem_req_addr, 32'h200);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    check_eq("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    step(1);
    @(negedge clk);
    check_eq("wrap_addr_zero", imem_req_addr, 32'h0);
    step(5);
    check_log("wrap", 3, 32'hFFFF_FFFC);
    check_log("wrap", 4, 32'h0);

    // Reset with a full buffer
    out_ready = 1'b0;
    do_reset();
    step(5);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rf_count_before", 32'(dut.u_fifo.count_q), 32'd2);
    check_eq("rf_req_valid_rst", 32'(imem_req_valid), 32'd0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rf_out_valid", 32'(out_valid), 32'd0);
    check_eq("rf_req_addr", imem_req_addr, 32'h0);
    check_eq("rf_count", 32'(dut.u_fifo.count_q), 32'd0);
    check_eq("rf_inflight", 32'(dut.inflight_q), 32'd0);
    check_eq("rf_drop", 32'(dut.drop_q), 32'd0);

    // Reset with two requests in flight: no stale responses afterwards
    out_ready = 1'b1;
    lat = 3;
    do_reset();
    step(2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("ri_inflight_before", 32'(dut.inflight_q), 32'd2);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ri_inflight", 32'(dut.inflight_q), 32'd0);
    check_eq("ri_req_addr", imem_req_addr, 32'h0);
    step(12);
    check_log("ri", 0, 32'h0);
    check_log("ri", 1, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  instruction memory accepts request; fire = valid & ready.
REQ-006 imem_req_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_resp_valid  input  1  response valid; responses return in request order, latency >= 1 cycle after fire.
REQ-008 imem_resp_data  input  32  fetched instruction word.
REQ-009 redirect_valid  input  1  control-flow redirect from execute (taken branch/jump).
REQ-010 redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-011 out_valid  output  1  instruction available to decoder.
REQ-012 out_ready  input  1  decoder accepts; out fire = out_valid & out_ready.
REQ-013 out_instruction  output  32  instruction word passed to decoder input.
REQ-014 out_pc  output  32  address of out_instruction.

Function
REQ-015 pc register holds next fetch address; imem_req_addr = pc; pc advances by 4 on request fire, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-016 Instruction buffer: 2-entry in-order FIFO of {pc, instruction}; out_* driven from head entry, registered (no combinational path from imem_resp_* to out_*).
REQ-017 inflight counter (0..2) counts fired requests awaiting response; increments on request fire, decrements on imem_resp_valid, both same cycle = no change.
REQ-018 Credit rule: imem_req_valid = !rst & !redirect_valid & (inflight + fifo_count - out_fire) < 2; FIFO therefore never overflows.
REQ-019 Latency: request fired cycle T, response cycle T+L -> out_valid cycle T+L+1.
REQ-020 Throughput: with L=1, imem_req_ready and out_ready held high, one out fire per cycle in steady state.
REQ-021 Response with drop_count = 0 is written to FIFO tail tagged with the pc of its request (tracked in issue order).
REQ-022 Simultaneous response write and out fire with FIFO full or empty: legal; count unchanged, order preserved.
REQ-023 Redirect cycle: no request issued; pc <= {redirect_pc[31:2],2'b00}; FIFO flushed (out fire in this cycle is still honoured by decoder but entries are cleared next edge); drop_count <= inflight - imem_resp_valid; a response arriving in this cycle is discarded.
REQ-024 While drop_count > 0, each imem_resp_valid is discarded (not written) and decrements drop_count; inflight still decrements.
REQ-025 Fetch resumes the cycle after redirect subject to REQ-018; discarded requests still occupy credits until their responses return.
REQ-026 Back-to-back redirects: latest redirect wins; drop_count recomputed per REQ-023 each redirect cycle.
REQ-027 out_valid low -> out_instruction = 32'h0000_0013 (NOP), out_pc = 0.
REQ-028 imem_req_valid, once high without fire, stays high with stable address unless redirect_valid or rst asserts.

Reset
REQ-029 On rst edge: pc = RESET_PC, FIFO empty, inflight = 0, drop_count = 0, out_valid = 0, imem_req_valid = 0 during rst.
REQ-030 rst mid-operation abandons all in-flight requests; instruction memory SHALL be reset by the same rst so no stale responses return.
REQ-031 First request issued in the first cycle with rst low.

Structure
REQ-032 Shared package holds: FETCH_DEPTH = 2, NOP_INSTR = 32'h0000_0013, XLEN = 32.
REQ-033 One sub-module: fetch_fifo (2-entry FIFO with flush, {pc,instr} payload, count output); pc/credit/drop logic stays in fetch_unit.

Verification
REQ-034 Reset release, RESET_PC=0, L=1, ready high -> requests 0x0,0x4,0x8...; out_pc 0x0 at cycle 2 after release, then one per cycle.
REQ-035 out_ready low for 5 cycles -> FIFO fills to 2, inflight 0, imem_req_valid low; release -> order 0x0,0x4,0x8 intact, no loss or duplicate.
REQ-036 L=3, two requests in flight, redirect to 0x100 -> both responses dropped, next out_pc = 0x100, drop_count returns to 0.
REQ-037 Redirect coincident with response and out fire -> response discarded, out_valid low next cycle, fetch of redirect target next cycle.
REQ-038 redirect_pc = 0x203 -> imem_req_addr = 0x200; pc at 0xFFFF_FFFC -> next request 0x0.
REQ-039 rst asserted with FIFO full and inflight 2 -> next cycle out_valid 0, imem_req_addr = RESET_PC, counters 0.
